// File: rtl/qpu_dispatch_pkg.sv
// Shared widths and the queued event layout for the QPU event dispatcher.
package qpu_dispatch_pkg;

  localparam int unsigned DEF_TIME_W = 32;
  localparam int unsigned DEF_CW_W   = 8;
  localparam int unsigned DEF_CH_NUM = 4;
  localparam int unsigned DEF_DEPTH  = 8;
  localparam int unsigned DEF_CH_W   = $clog2(DEF_CH_NUM);

  // Queue entry at default widths; the dispatcher packs the same field order.
  typedef struct packed {
    logic [DEF_TIME_W-1:0] ev_time;
    logic [DEF_CH_W-1:0]   chan;
    logic [DEF_CW_W-1:0]   cw;
  } entry_t;

  function automatic int unsigned entry_width(input int unsigned time_w,
                                              input int unsigned ch_w,
                                              input int unsigned cw_w);
    return time_w + ch_w + cw_w;
  endfunction

endpackage

// File: rtl/qpu_sync_fifo.sv
// Register-based synchronous FIFO; callers never push when full or pop when empty.
module qpu_sync_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  // Pointers wrap naturally at DEPTH (power of two); count tells full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];

endmodule

// File: rtl/qpu_event_dispatch.sv
// Timed event dispatcher: queues timestamped codewords and strobes them onto
// their channel when the free-running timer reaches the event time.
module qpu_event_dispatch import qpu_dispatch_pkg::*; #(
  parameter  int unsigned TIME_W = DEF_TIME_W,
  parameter  int unsigned CW_W   = DEF_CW_W,
  parameter  int unsigned CH_NUM = DEF_CH_NUM,
  parameter  int unsigned DEPTH  = DEF_DEPTH,
  localparam int unsigned CH_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [TIME_W-1:0] i_time,
  input  logic [CH_W-1:0]   i_chan,
  input  logic [CW_W-1:0]   i_cw,
  input  logic              tmr_en,
  input  logic              tmr_clr,
  input  logic              clr_err,
  output logic [CH_NUM-1:0] o_valid,
  output logic [CW_W-1:0]   o_cw,
  output logic [TIME_W-1:0] cur_time,
  output logic [CNT_W-1:0]  count,
  output logic              late_err
);

  localparam int unsigned ENTRY_W = entry_width(TIME_W, CH_W, CW_W);

  logic [ENTRY_W-1:0] head;
  logic [TIME_W-1:0]  head_time;
  logic [CH_W-1:0]    head_chan;
  logic [CW_W-1:0]    head_cw;
  logic [TIME_W-1:0]  diff_c;
  logic               push_c;
  logic               pop_c;
  logic               empty_c;
  logic               hit_c;
  logic               late_c;
  logic               chan_ok_c;

  qpu_sync_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .pop   (pop_c),
    .wdata ({i_time, i_chan, i_cw}),
    .rdata (head),
    .count (count)
  );

  assign i_ready = (count != CNT_W'(DEPTH));
  assign push_c  = i_valid && i_ready;
  assign empty_c = (count == '0);

  // Modular distance from head time: MSB set means the head is still in the future.
  assign {head_time, head_chan, head_cw} = head;
  assign diff_c    = cur_time - head_time;
  assign pop_c     = !empty_c && !diff_c[TIME_W-1];
  assign hit_c     = pop_c && (diff_c == '0);
  assign late_c    = pop_c && (diff_c != '0);
  assign chan_ok_c = ({1'b0, head_chan} < (CH_W+1)'(CH_NUM));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          cur_time <= '0;
    else if (tmr_clr) cur_time <= '0;
    else if (tmr_en)  cur_time <= cur_time + TIME_W'(1);
  end

  // Issue strobe is one cycle wide; out-of-range channels are consumed silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid  <= '0;
      o_cw     <= '0;
      late_err <= 1'b0;
    end else begin
      o_valid <= '0;
      if (hit_c && chan_ok_c) begin
        o_valid <= CH_NUM'(1) << head_chan;
        o_cw    <= head_cw;
      end
      if (late_c)       late_err <= 1'b1;
      else if (clr_err) late_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_qpu_event_dispatch.sv
// Directed bench for qpu_event_dispatch: a default-width instance plus a narrow
// 8-bit-timer, 3-channel instance used for wrap-around and invalid-channel cases.
module tb_qpu_event_dispatch;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] i_time;
  logic [1:0]  i_chan;
  logic [7:0]  i_cw;
  logic        tmr_en;
  logic        tmr_clr;
  logic        clr_err;
  logic [3:0]  o_valid;
  logic [7:0]  o_cw;
  logic [31:0] cur_time;
  logic [3:0]  count;
  logic        late_err;

  logic        w_valid;
  logic        w_ready;
  logic [7:0]  w_time;
  logic [1:0]  w_chan;
  logic [7:0]  w_cw;
  logic        w_tmr_en;
  logic        w_tmr_clr;
  logic        w_clr_err;
  logic [2:0]  w_ovalid;
  logic [7:0]  w_ocw;
  logic [7:0]  w_ct;
  logic [2:0]  w_count;
  logic        w_late;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  qpu_event_dispatch dut (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (i_valid),
    .i_ready  (i_ready),
    .i_time   (i_time),
    .i_chan   (i_chan),
    .i_cw     (i_cw),
    .tmr_en   (tmr_en),
    .tmr_clr  (tmr_clr),
    .clr_err  (clr_err),
    .o_valid  (o_valid),
    .o_cw     (o_cw),
    .cur_time (cur_time),
    .count    (count),
    .late_err (late_err)
  );

  qpu_event_dispatch #(
    .TIME_W (8),
    .CW_W   (8),
    .CH_NUM (3),
    .DEPTH  (4)
  ) dut_w (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (w_valid),
    .i_ready  (w_ready),
    .i_time   (w_time),
    .i_chan   (w_chan),
    .i_cw     (w_cw),
    .tmr_en   (w_tmr_en),
    .tmr_clr  (w_tmr_clr),
    .clr_err  (w_clr_err),
    .o_valid  (w_ovalid),
    .o_cw     (w_ocw),
    .cur_time (w_ct),
    .count    (w_count),
    .late_err (w_late)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ct(input logic [31:0] target, input int budget);
    for (int i = 0; i < budget && cur_time != target; i++) tick();
    chk("wait_cur_time", 64'(cur_time), 64'(target));
  endtask

  initial begin
    int n;
    rst = 1'b1;
    i_valid = 1'b0; i_time = '0; i_chan = '0; i_cw = '0;
    tmr_en = 1'b0; tmr_clr = 1'b0; clr_err = 1'b0;
    w_valid = 1'b0; w_time = '0; w_chan = '0; w_cw = '0;
    w_tmr_en = 1'b0; w_tmr_clr = 1'b0; w_clr_err = 1'b0;
    tick();
    tick();
    chk("rst_count",    64'(count),    64'd0);
    chk("rst_ready",    64'(i_ready),  64'd1);
    chk("rst_cur_time", 64'(cur_time), 64'd0);
    chk("rst_o_valid",  64'(o_valid),  64'd0);
    chk("rst_o_cw",     64'(o_cw),     64'd0);
    chk("rst_late_err", 64'(late_err), 64'd0);
    rst = 1'b0;

    // Single event at time 5 on channel 2
    i_valid = 1'b1; i_time = 32'd5; i_chan = 2'd2; i_cw = 8'hA5; tmr_en = 1'b1;
    tick();
    i_valid = 1'b0;
    chk("t1_count_after_push", 64'(count), 64'd1);
    wait_ct(32'd5, 20);
    chk("t1_no_early_strobe", 64'(o_valid), 64'd0);
    tick();
    chk("t1_o_valid", 64'(o_valid),  64'h4);
    chk("t1_o_cw",    64'(o_cw),     64'hA5);
    chk("t1_count",   64'(count),    64'd0);
    chk("t1_late",    64'(late_err), 64'd0);
    tick();
    chk("t1_strobe_one_cycle", 64'(o_valid), 64'd0);
    chk("t1_o_cw_hold",        64'(o_cw),    64'hA5);

    // Fill to full with times 100..107, ninth push refused
    tmr_en = 1'b0; tmr_clr = 1'b1;
    tick();
    tmr_clr = 1'b0;
    chk("t2_timer_cleared", 64'(cur_time), 64'd0);
    for (int i = 0; i < 8; i++) begin
      i_valid = 1'b1; i_time = 32'(100 + i); i_chan = 2'(i % 4); i_cw = 8'(16 + i);
      tick();
    end
    chk("t2_full_count", 64'(count),   64'd8);
    chk("t2_full_ready", 64'(i_ready), 64'd0);
    i_time = 32'd200; i_chan = 2'd0; i_cw = 8'hFF;
    tick();
    i_valid = 1'b0;
    chk("t2_ninth_refused", 64'(count),   64'd8);
    chk("t2_no_strobe",     64'(o_valid), 64'd0);
    tmr_en = 1'b1;
    wait_ct(32'd100, 150);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("t2_order_valid", 64'(o_valid), 64'(1 << (i % 4)));
      chk("t2_order_cw",    64'(o_cw),    64'(16 + i));
      tick();
    end
    chk("t2_drained_valid", 64'(o_valid),  64'd0);
    chk("t2_drained_count", 64'(count),    64'd0);
    chk("t2_late",          64'(late_err), 64'd0);

    // Late event at timer 50, then clear; late drop beats a same-cycle clear
    tmr_en = 1'b0; tmr_clr = 1'b1;
    tick();
    tmr_clr = 1'b0; tmr_en = 1'b1;
    wait_ct(32'd50, 80);
    tmr_en = 1'b0;
    i_valid = 1'b1; i_time = 32'd20; i_chan = 2'd1; i_cw = 8'h33;
    tick();
    i_valid = 1'b0;
    chk("t3_queued", 64'(count),    64'd1);
    chk("t3_no_err", 64'(late_err), 64'd0);
    tick();
    chk("t3_dropped",   64'(count),    64'd0);
    chk("t3_no_strobe", 64'(o_valid),  64'd0);
    chk("t3_late_set",  64'(late_err), 64'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("t3_late_clr", 64'(late_err), 64'd0);
    i_valid = 1'b1; i_time = 32'd20; i_chan = 2'd1; i_cw = 8'h44;
    tick();
    chk("t3_a_queued", 64'(count), 64'd1);
    clr_err = 1'b1; i_time = 32'd20; i_chan = 2'd0; i_cw = 8'h55;
    tick();
    i_valid = 1'b0; clr_err = 1'b0;
    chk("t3_push_pop_count", 64'(count),    64'd1);
    chk("t3_late_beats_clr", 64'(late_err), 64'd1);
    chk("t3_no_strobe2",     64'(o_valid),  64'd0);
    tick();
    chk("t3_b_dropped", 64'(count),    64'd0);
    chk("t3_late_held", 64'(late_err), 64'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("t3_late_clr2", 64'(late_err), 64'd0);

    // Two events at time 10 with timer running: second is late
    tmr_en = 1'b0; tmr_clr = 1'b1;
    tick();
    tmr_clr = 1'b0;
    i_valid = 1'b1; i_time = 32'd10; i_chan = 2'd0; i_cw = 8'h01;
    tick();
    i_chan = 2'd1; i_cw = 8'h02;
    tick();
    i_valid = 1'b0;
    chk("t4_two_queued", 64'(count), 64'd2);
    tmr_en = 1'b1;
    wait_ct(32'd10, 20);
    tick();
    chk("t4_first_valid", 64'(o_valid), 64'h1);
    chk("t4_first_cw",    64'(o_cw),    64'h01);
    tick();
    chk("t4_second_no_strobe", 64'(o_valid),  64'd0);
    chk("t4_second_late",      64'(late_err), 64'd1);
    chk("t4_count",            64'(count),    64'd0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;

    // Same pair with the timer stopped at 10: both issue back to back
    tmr_en = 1'b0; tmr_clr = 1'b1;
    tick();
    tmr_clr = 1'b0;
    i_valid = 1'b1; i_time = 32'd10; i_chan = 2'd0; i_cw = 8'h01;
    tick();
    i_chan = 2'd1; i_cw = 8'h02;
    tick();
    i_valid = 1'b0;
    tmr_en = 1'b1;
    wait_ct(32'd10, 20);
    tmr_en = 1'b0;
    tick();
    chk("t5_first_valid", 64'(o_valid), 64'h1);
    chk("t5_first_cw",    64'(o_cw),    64'h01);
    tick();
    chk("t5_second_valid", 64'(o_valid), 64'h2);
    chk("t5_second_cw",    64'(o_cw),    64'h02);
    tick();
    chk("t5_idle",  64'(o_valid),  64'd0);
    chk("t5_late",  64'(late_err), 64'd0);
    chk("t5_count", 64'(count),    64'd0);

    // Reset mid-operation discards queued events
    tmr_clr = 1'b1;
    tick();
    tmr_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_valid = 1'b1; i_time = 32'(3 + i); i_chan = 2'd2; i_cw = 8'(8'h61 + i);
      tick();
    end
    i_valid = 1'b0;
    tmr_en = 1'b1;
    wait_ct(32'd4, 20);
    chk("t6_strobe_before_rst", 64'(o_valid), 64'h4);
    chk("t6_count_before_rst",  64'(count),   64'd2);
    rst = 1'b1;
    #1;
    chk("t6_rst_count",    64'(count),    64'd0);
    chk("t6_rst_o_valid",  64'(o_valid),  64'd0);
    chk("t6_rst_cur_time", 64'(cur_time), 64'd0);
    chk("t6_rst_ready",    64'(i_ready),  64'd1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t6_no_strobe_after_rst", 64'(o_valid), 64'd0);
    end
    chk("t6_count_after", 64'(count), 64'd0);
    tmr_en = 1'b0;

    // Narrow timer: event at 1 queued at 0xFE waits across the wrap
    w_tmr_clr = 1'b1;
    tick();
    w_tmr_clr = 1'b0; w_tmr_en = 1'b1;
    for (int i = 0; i < 300 && w_ct != 8'hFE; i++) tick();
    chk("w_reach_fe", 64'(w_ct), 64'hFE);
    w_tmr_en = 1'b0;
    w_valid = 1'b1; w_time = 8'h01; w_chan = 2'd2; w_cw = 8'h5C;
    tick();
    w_valid = 1'b0;
    chk("w_queued", 64'(w_count), 64'd1);
    w_tmr_en = 1'b1;
    n = 0;
    for (int i = 0; i < 10 && w_ct != 8'h01; i++) begin
      chk("w_waits_no_strobe", 64'(w_ovalid), 64'd0);
      tick();
      n++;
    end
    chk("w_wrap_ticks", 64'(n),      64'd3);
    chk("w_ct_one",     64'(w_ct),   64'h01);
    chk("w_still_wait", 64'(w_count), 64'd1);
    tick();
    chk("w_issue_valid", 64'(w_ovalid), 64'h4);
    chk("w_issue_cw",    64'(w_ocw),    64'h5C);
    chk("w_issue_count", 64'(w_count),  64'd0);
    chk("w_no_late",     64'(w_late),   64'd0);

    // Out-of-range channel is consumed with no strobe and no error
    w_tmr_en = 1'b0;
    w_valid = 1'b1; w_time = w_ct; w_chan = 2'd3; w_cw = 8'h77;
    tick();
    w_valid = 1'b0;
    chk("w_badch_queued", 64'(w_count), 64'd1);
    tick();
    chk("w_badch_no_strobe", 64'(w_ovalid), 64'd0);
    chk("w_badch_no_err",    64'(w_late),   64'd0);
    chk("w_badch_consumed",  64'(w_count),  64'd0);
    chk("w_badch_cw_hold",   64'(w_ocw),    64'h5C);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
